// File: rtl/seq_pkg.sv
// Shared FSM encoding, operand slot indices and a sizing helper for operand_sequencer.
package seq_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_PRESS,
      S_RELEASE,
      S_WAIT_RES,
      S_DONE,
      S_ERR
   } state_t;

   localparam logic [1:0] IDX_A = 2'd0;
   localparam logic [1:0] IDX_B = 2'd1;
   localparam logic [1:0] IDX_C = 2'd2;
   localparam logic [1:0] IDX_X = 2'd3;

   function automatic int max4(input int a, input int b, input int c, input int d);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return m;
   endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter that parks at zero; a load takes priority over counting.
// The zero flag reflects the current count, so a phase of N cycles is loaded with N-1.
module phase_timer #(
   parameter int W = 6
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         zero
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load)
         cnt_d = load_val;
      else if (cnt_q != '0)
         cnt_d = cnt_q - W'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign zero = (cnt_q == '0);

endmodule

// File: rtl/operand_sequencer.sv
// Serially loads a snapshotted {A,B,C,X} set into the polynomial evaluator with Go strobes,
// then waits for a ResultValid rising edge to capture the result, or times out.
module operand_sequencer
   import seq_pkg::*;
#(
   parameter int DATA_W         = 8,
   parameter int SETUP_CYCLES   = 1,
   parameter int PRESS_CYCLES   = 2,
   parameter int RELEASE_CYCLES = 2,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic              Clock,
   input  logic              Reset,
   input  logic              Start,
   input  logic [DATA_W-1:0] OpA,
   input  logic [DATA_W-1:0] OpB,
   input  logic [DATA_W-1:0] OpC,
   input  logic [DATA_W-1:0] OpX,
   input  logic              ResultValid,
   input  logic [DATA_W-1:0] DataResult,
   output logic [DATA_W-1:0] DataIn,
   output logic              Go,
   output logic              Busy,
   output logic [DATA_W-1:0] Result,
   output logic              Done,
   output logic              Timeout
);

   localparam int MAX_CYC = max4(SETUP_CYCLES, PRESS_CYCLES, RELEASE_CYCLES, TIMEOUT_CYCLES);
   localparam int TW      = (MAX_CYC < 2) ? 1 : $clog2(MAX_CYC);

   localparam logic [TW-1:0] LD_SETUP   = TW'(SETUP_CYCLES - 1);
   localparam logic [TW-1:0] LD_PRESS   = TW'(PRESS_CYCLES - 1);
   localparam logic [TW-1:0] LD_RELEASE = TW'(RELEASE_CYCLES - 1);
   localparam logic [TW-1:0] LD_TIMEOUT = TW'(TIMEOUT_CYCLES - 1);

   state_t            state_q, state_d;
   logic [1:0]        idx_q, idx_d;
   logic [DATA_W-1:0] ops_q [4];
   logic [DATA_W-1:0] ops_d [4];
   logic [DATA_W-1:0] data_in_q, data_in_d;
   logic [DATA_W-1:0] result_q, result_d;
   logic              go_q, go_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              timeout_q, timeout_d;
   logic              rv_q, rv_d;

   logic              tmr_load;
   logic [TW-1:0]     tmr_val;
   logic              tmr_zero;
   logic [1:0]        idx_nxt;

   assign idx_nxt = idx_q + 2'd1;

   phase_timer #(.W(TW)) u_timer (
      .clk      (Clock),
      .rst      (Reset),
      .load     (tmr_load),
      .load_val (tmr_val),
      .zero     (tmr_zero)
   );

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      ops_d     = ops_q;
      data_in_d = data_in_q;
      result_d  = result_q;
      go_d      = go_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      timeout_d = 1'b0;
      rv_d      = ResultValid;
      tmr_load  = 1'b0;
      tmr_val   = '0;

      unique case (state_q)
         S_IDLE: begin
            if (Start) begin
               ops_d[0]  = OpA;
               ops_d[1]  = OpB;
               ops_d[2]  = OpC;
               ops_d[3]  = OpX;
               idx_d     = IDX_A;
               data_in_d = OpA;
               busy_d    = 1'b1;
               tmr_load  = 1'b1;
               tmr_val   = LD_SETUP;
               state_d   = S_SETUP;
            end
         end
         S_SETUP: begin
            if (tmr_zero) begin
               go_d     = 1'b1;
               tmr_load = 1'b1;
               tmr_val  = LD_PRESS;
               state_d  = S_PRESS;
            end
         end
         S_PRESS: begin
            if (tmr_zero) begin
               go_d     = 1'b0;
               tmr_load = 1'b1;
               tmr_val  = LD_RELEASE;
               state_d  = S_RELEASE;
            end
         end
         S_RELEASE: begin
            // DataIn only moves here, one full setup window ahead of the next Go.
            if (tmr_zero) begin
               tmr_load = 1'b1;
               if (idx_q == IDX_X) begin
                  tmr_val = LD_TIMEOUT;
                  state_d = S_WAIT_RES;
               end else begin
                  idx_d     = idx_nxt;
                  data_in_d = ops_q[idx_nxt];
                  tmr_val   = LD_SETUP;
                  state_d   = S_SETUP;
               end
            end
         end
         S_WAIT_RES: begin
            // Edge-only acceptance: the evaluator idles with ResultValid high from the last run.
            if (ResultValid && !rv_q) begin
               result_d = DataResult;
               done_d   = 1'b1;
               state_d  = S_DONE;
            end else if (tmr_zero) begin
               timeout_d = 1'b1;
               state_d   = S_ERR;
            end
         end
         S_DONE, S_ERR: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state_q   <= S_IDLE;
         idx_q     <= IDX_A;
         ops_q     <= '{default: '0};
         data_in_q <= '0;
         result_q  <= '0;
         go_q      <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         timeout_q <= 1'b0;
         rv_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         ops_q     <= ops_d;
         data_in_q <= data_in_d;
         result_q  <= result_d;
         go_q      <= go_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         timeout_q <= timeout_d;
         rv_q      <= rv_d;
      end
   end

   assign DataIn  = data_in_q;
   assign Go      = go_q;
   assign Busy    = busy_q;
   assign Result  = result_q;
   assign Done    = done_q;
   assign Timeout = timeout_q;

endmodule

// File: tb/tb_operand_sequencer.sv
// Bench: operand_sequencer driving a behavioural serial-load polynomial evaluator.
module tb_operand_sequencer;

   localparam int PRESS_CYCLES   = 2;
   localparam int RELEASE_CYCLES = 2;
   localparam int TIMEOUT_CYCLES = 64;

   logic       Clock;
   logic       Reset;
   logic       Start;
   logic [7:0] OpA, OpB, OpC, OpX;
   logic       ResultValid;
   logic [7:0] DataResult;
   logic [7:0] DataIn;
   logic       Go, Busy, Done, Timeout;
   logic [7:0] Result;

   operand_sequencer #(
      .DATA_W(8), .SETUP_CYCLES(1), .PRESS_CYCLES(PRESS_CYCLES),
      .RELEASE_CYCLES(RELEASE_CYCLES), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) dut (
      .Clock(Clock), .Reset(Reset), .Start(Start),
      .OpA(OpA), .OpB(OpB), .OpC(OpC), .OpX(OpX),
      .ResultValid(ResultValid), .DataResult(DataResult),
      .DataIn(DataIn), .Go(Go), .Busy(Busy), .Result(Result),
      .Done(Done), .Timeout(Timeout)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   int tests = 0;
   int fails = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Evaluator model: latches on each Go rise, computes 5 cycles after the 4th operand.
   logic [1:0] ev_mode;
   logic [7:0] ev_ops [4];
   logic [1:0] ev_n;
   logic       ev_go_d;
   logic       ev_rv;
   logic [7:0] ev_res;
   int         ev_cnt;

   always @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         ev_n    <= 2'd0;
         ev_go_d <= 1'b0;
         ev_rv   <= 1'b0;
         ev_res  <= 8'd0;
         ev_cnt  <= 0;
      end else begin
         ev_go_d <= Go;
         if (Go && !ev_go_d) begin
            ev_ops[ev_n] <= DataIn;
            ev_rv        <= 1'b0;
            ev_n         <= ev_n + 2'd1;
            if (ev_n == 2'd3) ev_cnt <= 5;
         end else if (ev_cnt != 0) begin
            ev_cnt <= ev_cnt - 1;
            if (ev_cnt == 1) begin
               ev_rv  <= 1'b1;
               ev_res <= ev_ops[0] * ev_ops[3] * ev_ops[3] + ev_ops[1] * ev_ops[3] + ev_ops[2];
            end
         end
      end
   end

   assign ResultValid = (ev_mode == 2'd0) ? ev_rv : (ev_mode == 2'd2);
   assign DataResult  = ev_res;

   // Scoreboards: operands expected under each Go pulse, results expected on each Done.
   logic [7:0] op_q [$];
   logic [7:0] sb_q [$];
   int         cyc = 0;
   int         go_rises = 0;
   int         done_cnt = 0;
   int         to_cnt = 0;
   int         fall_cyc = 0;
   int         m_width = 0;
   logic       m_go_prev = 1'b0;
   logic [7:0] m_din_prev = 8'd0;
   logic [7:0] cur_op = 8'd0;

   always @(posedge Clock) cyc <= cyc + 1;

   always @(negedge Clock) begin
      if (Reset) begin
         m_go_prev = 1'b0;
         m_width   = 0;
      end else begin
         if (Go && !m_go_prev) begin
            go_rises++;
            m_width = 0;
            if (op_q.size() == 0) chk("go_unexpected", Go, 0);
            else begin
               cur_op = op_q.pop_front();
               chk("datain_setup", m_din_prev, cur_op);
            end
         end
         if (Go) begin
            m_width++;
            chk("datain_under_go", DataIn, cur_op);
         end
         if (!Go && m_go_prev) begin
            chk("go_width", m_width, PRESS_CYCLES);
            chk("datain_release", DataIn, cur_op);
            fall_cyc = cyc;
         end
         if (Done) begin
            done_cnt++;
            if (sb_q.size() == 0) chk("done_unexpected", Done, 0);
            else chk("result", Result, sb_q.pop_front());
         end
         if (Timeout) begin
            to_cnt++;
            chk("timeout_latency", cyc - fall_cyc, RELEASE_CYCLES + TIMEOUT_CYCLES);
         end
         m_go_prev = Go;
      end
      m_din_prev = DataIn;
   end

   task automatic start_seq(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                            input logic [7:0] x, input bit expect_done, input logic [7:0] exp);
      OpA = a; OpB = b; OpC = c; OpX = x;
      Start = 1'b1;
      op_q.push_back(a); op_q.push_back(b); op_q.push_back(c); op_q.push_back(x);
      if (expect_done) sb_q.push_back(exp);
      @(negedge Clock);
      Start = 1'b0;
      chk("busy_after_start", Busy, 1);
   endtask

   task automatic wait_end(input int max_cyc, output int kind);
      kind = 0;
      for (int i = 0; i < max_cyc; i++) begin
         @(negedge Clock);
         if (Done) begin kind = 1; break; end
         if (Timeout) begin kind = 2; break; end
      end
   endtask

   task automatic wait_go_rises(input int n);
      int   seen;
      logic prev;
      seen = 0;
      prev = Go;
      for (int i = 0; i < 200 && seen < n; i++) begin
         @(negedge Clock);
         if (Go && !prev) seen++;
         prev = Go;
      end
      chk("go_rise_wait", seen, n);
   endtask

   initial begin
      int k;
      int base;
      int d0;

      Reset = 1'b1; Start = 1'b0; ev_mode = 2'd0;
      OpA = 8'd0; OpB = 8'd0; OpC = 8'd0; OpX = 8'd0;
      repeat (3) @(negedge Clock);
      chk("rst_go", Go, 0);
      chk("rst_datain", DataIn, 0);
      chk("rst_busy", Busy, 0);
      chk("rst_result", Result, 0);
      chk("rst_done", Done, 0);
      chk("rst_timeout", Timeout, 0);
      Reset = 1'b0;
      repeat (2) @(negedge Clock);

      // Basic sequence: 1,2,3,4 -> 27
      base = go_rises;
      start_seq(8'd1, 8'd2, 8'd3, 8'd4, 1'b1, 8'd27);
      wait_end(200, k);
      chk("run1_end", k, 1);
      chk("run1_go_pulses", go_rises - base, 4);
      @(negedge Clock);
      chk("run1_busy_fall", Busy, 0);
      chk("run1_done_width", Done, 0);

      // Truncation, then an immediate back-to-back run that must not reuse the stale result
      start_seq(8'd5, 8'd0, 8'd0, 8'd10, 1'b1, 8'd244);
      wait_end(200, k);
      chk("run2_end", k, 1);
      @(negedge Clock);
      chk("run2_busy_fall", Busy, 0);
      start_seq(8'd0, 8'd0, 8'd7, 8'd9, 1'b1, 8'd7);
      wait_end(200, k);
      chk("run3_end", k, 1);
      chk("run3_result_fresh", Result, 7);

      // Start pulsed during PRESS of operand B is ignored
      repeat (3) @(negedge Clock);
      d0 = done_cnt;
      start_seq(8'd2, 8'd3, 8'd4, 8'd5, 1'b1, 8'd69);
      wait_go_rises(2);
      OpA = 8'd9; OpB = 8'd9; OpC = 8'd9; OpX = 8'd9;
      Start = 1'b1;
      @(negedge Clock);
      Start = 1'b0;
      wait_end(200, k);
      chk("run4_end", k, 1);
      repeat (40) @(negedge Clock);
      chk("run4_single_done", done_cnt - d0, 1);
      chk("run4_idle", Busy, 0);

      // Evaluator never answers
      ev_mode = 2'd1;
      repeat (3) @(negedge Clock);
      d0 = done_cnt;
      base = to_cnt;
      start_seq(8'd1, 8'd1, 8'd1, 8'd1, 1'b0, 8'd0);
      wait_end(300, k);
      chk("run5_end", k, 2);
      chk("run5_no_done", done_cnt - d0, 0);
      chk("run5_result_hold", Result, 69);
      @(negedge Clock);
      chk("run5_timeout_width", Timeout, 0);
      chk("run5_busy_fall", Busy, 0);
      chk("run5_timeout_count", to_cnt - base, 1);

      // ResultValid stuck high: level without an edge is rejected
      ev_mode = 2'd2;
      repeat (3) @(negedge Clock);
      d0 = done_cnt;
      start_seq(8'd4, 8'd3, 8'd2, 8'd1, 1'b0, 8'd0);
      wait_end(300, k);
      chk("run6_end", k, 2);
      chk("run6_no_done", done_cnt - d0, 0);
      chk("run6_result_hold", Result, 69);

      // Asynchronous reset mid-PRESS of operand C, then a clean run
      ev_mode = 2'd0;
      repeat (3) @(negedge Clock);
      start_seq(8'd3, 8'd1, 8'd2, 8'd6, 1'b1, 8'd116);
      wait_go_rises(3);
      chk("pre_reset_go", Go, 1);
      Reset = 1'b1;
      #1;
      chk("arst_go", Go, 0);
      chk("arst_busy", Busy, 0);
      chk("arst_datain", DataIn, 0);
      chk("arst_result", Result, 0);
      chk("arst_done", Done, 0);
      chk("arst_timeout", Timeout, 0);
      op_q.delete();
      sb_q.delete();
      repeat (2) @(negedge Clock);
      Reset = 1'b0;
      repeat (2) @(negedge Clock);
      start_seq(8'd3, 8'd1, 8'd2, 8'd6, 1'b1, 8'd116);
      wait_end(200, k);
      chk("run7_end", k, 1);
      chk("run7_result", Result, 116);
      @(negedge Clock);
      chk("run7_busy_fall", Busy, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
